ifetch_ctrl: RTL and testbench
==============================

IFETCH_CTRL -- requirements
Module: ifetch_ctrl

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL provide port clk  input  1  rising-edge clock for all state.
REQ-003 SHALL provide port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-004 SHALL provide port redirect  input  1  taken branch/jal/jalr resolved this cycle.
REQ-005 SHALL provide port redirect_pc  input  32  redirect target address.
REQ-006 SHALL provide port imem_req  output  1  instruction memory request.
REQ-007 SHALL provide port imem_addr  output  32  instruction memory word address.
REQ-008 SHALL provide port imem_ack  input  1  one-cycle response strobe; imem_rdata valid in the same cycle.
REQ-009 SHALL provide port imem_rdata  input  32  instruction word.
REQ-010 SHALL provide port if_valid  output  1  if_pc/if_instr hold a fetched instruction.
REQ-011 SHALL provide port if_ready  input  1  decode accepts the instruction this cycle.
REQ-012 SHALL provide port if_pc  output  32  PC of the presented instruction.
REQ-013 SHALL provide port if_instr  output  32  presented instruction word.
REQ-014 SHALL provide port busy  output  1  high while a memory request is outstanding.

Function
REQ-015 SHALL implement FSM states IDLE, REQ, HOLD; state, pc_q and the output register are all flops.
REQ-016 SHALL, in IDLE, drive imem_req=0 and move to REQ on the next edge.
REQ-017 SHALL, in REQ, drive imem_req=1 and imem_addr=pc_q, holding both stable until imem_ack, redirect or reset.
REQ-018 SHALL, on imem_ack without redirect, load if_pc=pc_q, if_instr=imem_rdata, if_valid=1, and set pc_q=pc_q+4 modulo 2^32, with wrap from 32'hFFFF_FFFC to 0.
REQ-019 SHALL treat the output register as drained when if_valid&if_ready; if_valid SHALL clear on drain unless a new instruction loads in the same cycle.
REQ-020 SHALL, after an accepted ack, stay in REQ if the output register is empty or drained that cycle, else go to HOLD.
REQ-021 SHALL, in HOLD, drive imem_req=0, keep if_pc/if_instr stable, and return to REQ on the cycle after drain.
REQ-022 SHALL give redirect priority over all other events in any state: pc_q=redirect_pc with bits [1:0] forced to 0, if_valid=0, any imem_ack in that cycle discarded, next state REQ.
REQ-023 SHALL ignore imem_ack in IDLE and HOLD.
REQ-024 SHALL drive busy = imem_req.
REQ-025 SHALL present the first instruction at if_valid one cycle after the imem_ack that returns it; back-to-back zero-wait acks sustain one instruction per cycle while if_ready=1.

Reset
REQ-026 SHALL, while reset=0, asynchronously force state=IDLE, pc_q=RESET_PC, if_valid=0, if_pc=0, if_instr=32'h0000_0013 (NOP), imem_req=0, busy=0.
REQ-027 SHALL discard any outstanding request when reset asserts mid-operation; a late imem_ack after release SHALL be ignored because the FSM is in IDLE.

Configuration
REQ-028 SHALL, with IFETCH_PERF_CNT_EN defined, add output stall_cycles (32 bits, reset 0) that increments, wrapping, every cycle with imem_req=1 and imem_ack=0, or with state HOLD.
REQ-029 SHALL, without IFETCH_PERF_CNT_EN, omit the stall_cycles port and counter entirely, with all other behaviour identical.

Verification
REQ-030 SHALL cover reset release with RESET_PC=32'h100 and immediate acks, if_ready=1 -> imem_addr 0x100, 0x104, 0x108 on consecutive REQ cycles; if_pc follows one cycle later.
REQ-031 SHALL cover a 3-cycle ack latency -> imem_req/imem_addr held stable for 3 cycles, busy=1, and stall_cycles=2 per fetch when the macro is on.
REQ-032 SHALL cover if_ready=0 after one fetch -> state HOLD, imem_req=0, if_instr stable; if_ready=1 -> REQ on the cycle after drain.
REQ-033 SHALL cover redirect=1 with redirect_pc=32'h203 in the same cycle as imem_ack -> response dropped, if_valid=0, next imem_addr=0x200.
REQ-034 SHALL cover pc_q=32'hFFFF_FFFC acked -> next imem_addr=0x0000_0000.
REQ-035 SHALL cover reset asserted during an outstanding request with an ack one cycle after release -> ack ignored, first request at RESET_PC.

Source files
------------

// File: rtl/ifetch_ctrl_if.sv
// Instruction-fetch bundle: redirect input, instruction-memory handshake
// and the decode-side output register. The master modport is the fetch
// controller; the slave modport is its environment (memory, decode, branch unit).
interface ifetch_ctrl_if;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        busy;

    modport master (
        input  redirect, redirect_pc, imem_ack, imem_rdata, if_ready,
        output imem_req, imem_addr, if_valid, if_pc, if_instr, busy
    );

    modport slave (
        output redirect, redirect_pc, imem_ack, imem_rdata, if_ready,
        input  imem_req, imem_addr, if_valid, if_pc, if_instr, busy
    );
endinterface

// File: rtl/ifetch_ctrl.sv
// Instruction fetch controller: IDLE -> REQ -> (HOLD) sequencer that issues
// word fetches at pc_q, captures each acked word into a one-entry output
// register for decode, and restarts at a word-aligned target on redirect.
// Optional feature: define IFETCH_PERF_CNT_EN to add the stall_cycles
// counter port (cycles waiting on memory or holding for decode).
module ifetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               reset,
    ifetch_ctrl_if.master      bus
`ifdef IFETCH_PERF_CNT_EN
    ,
    output logic [31:0]        stall_cycles
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic        req_q;
    logic        valid_q;
    logic [31:0] if_pc_q;
    logic [31:0] instr_q;

    logic [31:0] pc_d;
    logic        drain_d;

    // Sequential-PC increment wraps naturally at 2^32.
    assign pc_d    = pc_q + 32'd4;
    assign drain_d = valid_q & bus.if_ready;

    // Fetch FSM with registered request and output register; redirect wins over everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            if_pc_q <= '0;
            instr_q <= 32'h0000_0013;
        end else if (bus.redirect) begin
            state_q <= REQ;
            req_q   <= 1'b1;
            pc_q    <= {bus.redirect_pc[31:2], 2'b00};
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= REQ;
                    req_q   <= 1'b1;
                end
                REQ: begin
                    if (bus.imem_ack) begin
                        if_pc_q <= pc_q;
                        instr_q <= bus.imem_rdata;
                        valid_q <= 1'b1;
                        pc_q    <= pc_d;
                        if (valid_q && !drain_d) begin
                            state_q <= HOLD;
                            req_q   <= 1'b0;
                        end
                    end else if (drain_d) begin
                        valid_q <= 1'b0;
                    end
                end
                HOLD: begin
                    if (drain_d) begin
                        valid_q <= 1'b0;
                        state_q <= REQ;
                        req_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imem_req  = req_q;
    assign bus.imem_addr = pc_q;
    assign bus.busy      = req_q;
    assign bus.if_valid  = valid_q;
    assign bus.if_pc     = if_pc_q;
    assign bus.if_instr  = instr_q;

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] stall_q;

    // Count cycles spent waiting on memory or holding for decode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q <= '0;
        end else if ((req_q && !bus.imem_ack) || (state_q == HOLD)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Directed self-checking bench for ifetch_ctrl with RESET_PC = 0x100.
module tb_ifetch_ctrl;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    ifetch_ctrl_if bus ();

`ifdef IFETCH_PERF_CNT_EN
    logic [31:0] stall_cycles;
`endif

    ifetch_ctrl #(
        .RESET_PC (32'h0000_0100)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus.master)
`ifdef IFETCH_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ack, input logic [31:0] rdata, input logic ready);
        bus.imem_ack   = ack;
        bus.imem_rdata = rdata;
        bus.if_ready   = ready;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        drive(1'b0, '0, 1'b0);

        // Reset values
        tick();
        tick();
        check("rst_req",   {31'd0, bus.imem_req}, 32'd0);
        check("rst_busy",  {31'd0, bus.busy},     32'd0);
        check("rst_valid", {31'd0, bus.if_valid}, 32'd0);
        check("rst_pc",    bus.if_pc,             32'h0);
        check("rst_instr", bus.if_instr,          32'h0000_0013);
`ifdef IFETCH_PERF_CNT_EN
        check("rst_stall", stall_cycles,          32'd0);
`endif
        reset = 1'b1;
        #1;
        check("idle_req",  {31'd0, bus.imem_req}, 32'd0);

        // Reset release, zero-wait acks, decode always ready
        tick();
        check("s1_req",   {31'd0, bus.imem_req}, 32'd1);
        check("s1_addr",  bus.imem_addr,         32'h100);
        check("s1_valid", {31'd0, bus.if_valid}, 32'd0);
        drive(1'b1, 32'hAAAA_0001, 1'b1);
        tick();
        check("s2_addr",  bus.imem_addr,         32'h104);
        check("s2_valid", {31'd0, bus.if_valid}, 32'd1);
        check("s2_pc",    bus.if_pc,             32'h100);
        check("s2_instr", bus.if_instr,          32'hAAAA_0001);
        drive(1'b1, 32'hAAAA_0002, 1'b1);
        tick();
        check("s3_addr",  bus.imem_addr,         32'h108);
        check("s3_pc",    bus.if_pc,             32'h104);
        check("s3_instr", bus.if_instr,          32'hAAAA_0002);
        drive(1'b1, 32'hAAAA_0003, 1'b1);
        tick();
        check("s4_addr",  bus.imem_addr,         32'h10C);
        check("s4_pc",    bus.if_pc,             32'h108);

        // Three-cycle ack latency on fetch of 0x10C
        drive(1'b0, 32'h0, 1'b1);
        tick();
        check("lat2_req",   {31'd0, bus.imem_req}, 32'd1);
        check("lat2_busy",  {31'd0, bus.busy},     32'd1);
        check("lat2_addr",  bus.imem_addr,         32'h10C);
        check("lat2_valid", {31'd0, bus.if_valid}, 32'd0);
        tick();
        check("lat3_req",   {31'd0, bus.imem_req}, 32'd1);
        check("lat3_addr",  bus.imem_addr,         32'h10C);
        drive(1'b1, 32'hBBBB_0001, 1'b1);
        tick();
        check("lat_pc",    bus.if_pc,    32'h10C);
        check("lat_instr", bus.if_instr, 32'hBBBB_0001);
        check("lat_addr",  bus.imem_addr, 32'h110);
`ifdef IFETCH_PERF_CNT_EN
        check("lat_stall", stall_cycles, 32'd2);
`endif

        // Decode stalls: full register plus a new ack -> HOLD
        drive(1'b1, 32'hCCCC_0001, 1'b0);
        tick();
        check("hold_req",   {31'd0, bus.imem_req}, 32'd0);
        check("hold_busy",  {31'd0, bus.busy},     32'd0);
        check("hold_valid", {31'd0, bus.if_valid}, 32'd1);
        check("hold_pc",    bus.if_pc,             32'h110);
        check("hold_instr", bus.if_instr,          32'hCCCC_0001);
        drive(1'b1, 32'hDEAD_BEEF, 1'b0);
        tick();
        check("hold2_req",   {31'd0, bus.imem_req}, 32'd0);
        check("hold2_instr", bus.if_instr,          32'hCCCC_0001);
        check("hold2_pc",    bus.if_pc,             32'h110);
        drive(1'b0, 32'h0, 1'b1);
        tick();
        check("drain_req",   {31'd0, bus.imem_req}, 32'd1);
        check("drain_addr",  bus.imem_addr,         32'h114);
        check("drain_valid", {31'd0, bus.if_valid}, 32'd0);
`ifdef IFETCH_PERF_CNT_EN
        check("hold_stall", stall_cycles, 32'd4);
`endif

        // Redirect coinciding with an ack drops the response
        drive(1'b1, 32'hEEEE_0001, 1'b1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h203;
        tick();
        bus.redirect = 1'b0;
        check("redir_valid", {31'd0, bus.if_valid}, 32'd0);
        check("redir_addr",  bus.imem_addr,         32'h200);
        check("redir_req",   {31'd0, bus.imem_req}, 32'd1);
        drive(1'b1, 32'hF000_0001, 1'b1);
        tick();
        check("redir_pc",    bus.if_pc,     32'h200);
        check("redir_instr", bus.if_instr,  32'hF000_0001);
        check("redir_next",  bus.imem_addr, 32'h204);

        // PC wrap at the top of the address space
        drive(1'b0, 32'h0, 1'b1);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'hFFFF_FFFC;
        tick();
        bus.redirect = 1'b0;
        check("wrap_addr0", bus.imem_addr, 32'hFFFF_FFFC);
        drive(1'b1, 32'h1234_5678, 1'b1);
        tick();
        check("wrap_addr1", bus.imem_addr, 32'h0000_0000);
        check("wrap_pc",    bus.if_pc,     32'hFFFF_FFFC);
        check("wrap_instr", bus.if_instr,  32'h1234_5678);

        // Reset mid-request, late ack after release is ignored
        drive(1'b0, 32'h0, 1'b1);
        tick();
        reset = 1'b0;
        #1;
        check("mrst_req",   {31'd0, bus.imem_req}, 32'd0);
        check("mrst_busy",  {31'd0, bus.busy},     32'd0);
        check("mrst_valid", {31'd0, bus.if_valid}, 32'd0);
        check("mrst_instr", bus.if_instr,          32'h0000_0013);
        tick();
        reset = 1'b1;
        drive(1'b1, 32'hBAD0_BAD0, 1'b1);
        tick();
        check("late_req",   {31'd0, bus.imem_req}, 32'd1);
        check("late_addr",  bus.imem_addr,         32'h100);
        check("late_valid", {31'd0, bus.if_valid}, 32'd0);
        drive(1'b0, 32'h0, 1'b1);
        tick();
        check("late_addr2",  bus.imem_addr,         32'h100);
        check("late_valid2", {31'd0, bus.if_valid}, 32'd0);
        check("late_instr",  bus.if_instr,          32'h0000_0013);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
